// File: rtl/regfile_dump_reader_if.sv
// ---------------------------------------------------------------------------
// regfile_dump_reader_if
// Streaming handshake bundle carrying register-dump words from the dump
// reader (master) to its consumer (slave).
//   dump_valid : word on dump_data/dump_index is valid (master -> slave)
//   dump_ready : consumer accepts the word on valid && ready at posedge
//   dump_data  : captured register value
//   dump_index : register number of dump_data
// ---------------------------------------------------------------------------
interface regfile_dump_reader_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);

  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_index;

  modport master (
    output dump_valid,
    output dump_data,
    output dump_index,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_data,
    input  dump_index,
    output dump_ready
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// ---------------------------------------------------------------------------
// regfile_dump_reader
// Debug readback engine: walks the register file x0..x(NUM_REGS-1) through a
// spare combinational read port and streams each value out over a
// valid/ready handshake. One word every two cycles when the consumer never
// stalls; the dump is not an atomic snapshot (each register is sampled at
// the end of its own READ cycle).
//
// Ports:
//   CLK        : clock, all state updates on posedge
//   rst        : synchronous active-high reset
//   start      : one-cycle dump request, ignored while busy
//   busy       : dump in progress (cycle after start accepted .. FIN)
//   done       : one-cycle pulse after the last word is accepted
//   rf_addr    : read address to the register file read port
//   rf_data    : combinational read data for rf_addr
//   dump       : master side of the dump stream (valid/ready/data/index)
//   dump_csum  : running rotate-XOR checksum of accepted words
//                (present only when REGDUMP_CHECKSUM_EN is defined)
//
// Optional feature macro: REGDUMP_CHECKSUM_EN
// ---------------------------------------------------------------------------
module regfile_dump_reader #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     rf_addr,
  input  logic [DATA_W-1:0]     rf_data,
  regfile_dump_reader_if.master dump
`ifdef REGDUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]     dump_csum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_e;

  state_e            state_q,   state_d;
  logic [ADDR_W-1:0] index_q,   index_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] data_q,    data_d;
  logic [ADDR_W-1:0] didx_q,    didx_d;
  logic              valid_q,   valid_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q,    csum_d;
`endif

  // State and output registers
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= IDLE;
      index_q   <= '0;
      rf_addr_q <= '0;
      data_q    <= '0;
      didx_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      rf_addr_q <= rf_addr_d;
      data_q    <= data_d;
      didx_q    <= didx_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    rf_addr_d = '0;
    data_d    = data_q;
    didx_d    = didx_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          index_d = '0;
          busy_d  = 1'b1;
          state_d = READ;
`ifdef REGDUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      // rf_addr already holds index_q, so rf_data is the value to capture
      READ: begin
        data_d  = rf_data;
        didx_d  = index_q;
        valid_d = 1'b1;
        state_d = SEND;
      end

      SEND: begin
        if (dump.dump_ready) begin
          valid_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
          csum_d  = {csum_q[DATA_W-2:0], csum_q[DATA_W-1]} ^ data_q;
`endif
          if (index_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            index_d   = index_q + ADDR_W'(1);
            rf_addr_d = index_q + ADDR_W'(1);
            state_d   = READ;
          end
        end
      end

      // done is high for this single cycle; busy drops on the next
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign rf_addr         = rf_addr_q;
  assign dump.dump_valid = valid_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_index = didx_q;
`ifdef REGDUMP_CHECKSUM_EN
  assign dump_csum       = csum_q;
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_regfile_dump_reader
// Bench for regfile_dump_reader: a behavioural register file, randomized
// consumer backpressure and a word-sequence reference model.
// ---------------------------------------------------------------------------
module tb_regfile_dump_reader;

  localparam int unsigned NREG   = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int          BUDGET = 3000;

  logic              CLK;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] dump_csum;
`endif

  logic [DATA_W-1:0] rf_mem [NREG];

  int checks;
  int errors;

  regfile_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dif ();

  regfile_dump_reader #(
    .NUM_REGS(NREG),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) u_dut (
    .CLK      (CLK),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .dump     (dif)
`ifdef REGDUMP_CHECKSUM_EN
    ,
    .dump_csum(dump_csum)
`endif
  );

  assign rf_data = rf_mem[rf_addr];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are observed and inputs changed at negedge
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"},  64'(busy), 64'(0));
    check_eq({tag, "_done"},  64'(done), 64'(0));
    check_eq({tag, "_valid"}, 64'(dif.dump_valid), 64'(0));
    check_eq({tag, "_addr"},  64'(rf_addr), 64'(0));
  endtask

  // One dump driven from IDLE. Expected words are the register-file contents
  // in index order; consumer stalls are random (ready_pct) plus an optional
  // forced stall. Optional: a start pulse at word restart_at, a reset at word
  // abort_at, a register write during the READ of wr_idx (wr_mode 1, must be
  // visible) or after wr_idx is accepted (wr_mode 2, must not be visible).
  task automatic run_dump(input int ready_pct, input int stall_at, input int stall_len,
                          input int restart_at, input int abort_at, input int wr_mode,
                          input int wr_idx, input logic [DATA_W-1:0] wr_val,
                          input bit fin_start);
    logic [DATA_W-1:0] exp_rf [NREG];
    logic [DATA_W-1:0] csum;
    int  nxt;
    int  cyc;
    int  stalls;
    int  first_v;
    bit  fin;
    bit  aborted;
    bit  acc;

    for (int i = 0; i < int'(NREG); i++) exp_rf[i] = rf_mem[i];
    if (wr_mode == 1) exp_rf[wr_idx] = wr_val;
    csum    = '0;
    nxt     = 0;
    stalls  = 0;
    first_v = -1;
    fin     = 1'b0;
    aborted = 1'b0;

    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    check_eq("busy_on_start", 64'(busy), 64'(1));

    while (!fin && cyc < BUDGET) begin
      acc = 1'b0;
      if (dif.dump_valid) begin
        if (first_v < 0) first_v = cyc;
        check_eq("word_index", 64'(dif.dump_index), 64'(nxt));
        check_eq("word_data",  64'(dif.dump_data),  64'(exp_rf[nxt]));
        check_eq("busy_in_dump", 64'(busy), 64'(1));
        if (nxt == abort_at) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          check_idle_outputs("abort");
          check_eq("abort_data",  64'(dif.dump_data),  64'(0));
          check_eq("abort_index", 64'(dif.dump_index), 64'(0));
`ifdef REGDUMP_CHECKSUM_EN
          check_eq("abort_csum", 64'(dump_csum), 64'(0));
`endif
          for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("abort_no_done", 64'(done), 64'(0));
            check_eq("abort_stay_idle", 64'(busy), 64'(0));
          end
          fin     = 1'b1;
          aborted = 1'b1;
        end else begin
          if (nxt == restart_at) start = 1'b1;
          if (nxt == stall_at && stalls < stall_len) begin
            dif.dump_ready = 1'b0;
            stalls++;
          end else begin
            dif.dump_ready = (int'($urandom_range(99)) < ready_pct);
          end
          acc = dif.dump_ready;
        end
      end else begin
        // ready while nothing is valid must have no effect
        dif.dump_ready = 1'($urandom_range(1));
        if (done) begin
          check_eq("done_word_count", 64'(nxt), 64'(NREG));
          fin = 1'b1;
        end else begin
          check_eq("rf_addr_read", 64'(rf_addr), 64'(nxt));
          if (wr_mode == 1 && nxt == wr_idx) rf_mem[wr_idx] = wr_val;
          if (wr_mode == 2 && nxt == wr_idx + 1) rf_mem[wr_idx] = wr_val;
        end
      end

      if (!fin) begin
        tick();
        cyc++;
        start = 1'b0;
        if (acc) begin
          csum = {csum[DATA_W-2:0], csum[DATA_W-1]} ^ exp_rf[nxt];
          nxt++;
          check_eq("valid_drop_after_accept", 64'(dif.dump_valid), 64'(0));
        end
      end
    end

    check_eq("dump_terminated", 64'(fin), 64'(1));

    if (fin && !aborted) begin
      check_eq("first_valid_latency", 64'(first_v), 64'(2));
      if (ready_pct == 100 && stall_len == 0) check_eq("done_latency", 64'(cyc), 64'(65));
`ifdef REGDUMP_CHECKSUM_EN
      check_eq("csum_at_done", 64'(dump_csum), 64'(csum));
`endif
      if (fin_start) start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("busy_after_done", 64'(busy), 64'(0));
      check_eq("done_single_pulse", 64'(done), 64'(0));
      tick();
      check_idle_outputs("idle_after_fin");
`ifdef REGDUMP_CHECKSUM_EN
      check_eq("csum_hold", 64'(dump_csum), 64'(csum));
`endif
    end
    dif.dump_ready = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < int'(NREG); i++) rf_mem[i] = 32'h1000_0000 + 32'(i);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    start          = 1'b0;
    dif.dump_ready = 1'b0;
    load_ramp();

    tick();
    tick();
    check_idle_outputs("reset");
    check_eq("reset_data",  64'(dif.dump_data),  64'(0));
    check_eq("reset_index", 64'(dif.dump_index), 64'(0));
`ifdef REGDUMP_CHECKSUM_EN
    check_eq("reset_csum", 64'(dump_csum), 64'(0));
`endif
    rst = 1'b0;
    tick();
    check_idle_outputs("post_reset");

    // Full dump with the consumer always ready
    run_dump(100, -1, 0, -1, -1, 0, 0, '0, 1'b0);
    // Five-cycle stall on index 3
    run_dump(100, 3, 5, -1, -1, 0, 0, '0, 1'b0);
    // start during SEND of index 10 and during FIN are ignored
    run_dump(100, -1, 0, 10, -1, 0, 0, '0, 1'b1);
    run_dump(100, -1, 0, -1, -1, 0, 0, '0, 1'b0);
    // Reset while index 7 waits in SEND, then a fresh dump
    run_dump(100, 7, 3, -1, 7, 0, 0, '0, 1'b0);
    run_dump(100, -1, 0, -1, -1, 0, 0, '0, 1'b0);
    // Writeback before x5 is sampled shows up; after it is accepted it does not
    run_dump(100, -1, 0, -1, -1, 1, 5, 32'hDEAD_BEEF, 1'b0);
    load_ramp();
    run_dump(100, -1, 0, -1, -1, 2, 5, 32'hDEAD_BEEF, 1'b0);

    // Random contents with random backpressure
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < int'(NREG); i++) rf_mem[i] = $urandom;
      run_dump(55, $urandom_range(31), $urandom_range(6), -1, -1, 0, 0, '0, 1'b0);
    end

`ifdef REGDUMP_CHECKSUM_EN
    for (int i = 0; i < int'(NREG); i++) rf_mem[i] = 32'h0000_0001;
    run_dump(100, -1, 0, -1, -1, 0, 0, '0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
